// File: rtl/ram_conteudo_elevador_pkg.sv
// rtl/ram_conteudo_elevador_pkg.sv - shared sizes, floor codes and slot entry type for the car content memory
package elevador_pkg;
    localparam int DEPTH  = 8;
    localparam int TIPO_W = 2;
    localparam int DEST_W = 2;
    localparam int ADDR_W = 4;
    localparam int SLOT_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    localparam logic [DEST_W-1:0] ANDAR_0 = 2'd0;
    localparam logic [DEST_W-1:0] ANDAR_1 = 2'd1;
    localparam logic [DEST_W-1:0] ANDAR_2 = 2'd2;
    localparam logic [DEST_W-1:0] ANDAR_3 = 2'd3;

    // Packed so the stored word is {tipo, destino}
    typedef struct packed {
        logic [TIPO_W-1:0] tipo;
        logic [DEST_W-1:0] destino;
    } entry_t;

    localparam entry_t ENTRY_VAZIA = '0;
endpackage

// File: rtl/ram_conteudo_elevador_if.sv
// rtl/ram_conteudo_elevador_if.sv - load/unload/read bus of the car content memory (RAM_CONTEUDO_CONT_EN adds quantidade/vazio)
interface ram_conteudo_elevador_if;
    import elevador_pkg::*;

    logic [TIPO_W-1:0] in_tipo_objeto;
    logic [DEST_W-1:0] in_destino_objeto;
    logic              weT;
    logic              shift;
    logic              tira_objetos;
    logic [DEST_W-1:0] andar_atual;
    logic [ADDR_W-1:0] addr;
    logic [TIPO_W-1:0] tipo_objeto;
    logic [DEST_W-1:0] destino_objeto;
    logic              tem_vaga;
`ifdef RAM_CONTEUDO_CONT_EN
    logic [CNT_W-1:0]  quantidade;
    logic              vazio;
`endif

`ifdef RAM_CONTEUDO_CONT_EN
    modport master (
        output in_tipo_objeto, in_destino_objeto, weT, shift, tira_objetos, andar_atual, addr,
        input  tipo_objeto, destino_objeto, tem_vaga, quantidade, vazio
    );
    modport slave (
        input  in_tipo_objeto, in_destino_objeto, weT, shift, tira_objetos, andar_atual, addr,
        output tipo_objeto, destino_objeto, tem_vaga, quantidade, vazio
    );
`else
    modport master (
        output in_tipo_objeto, in_destino_objeto, weT, shift, tira_objetos, andar_atual, addr,
        input  tipo_objeto, destino_objeto, tem_vaga
    );
    modport slave (
        input  in_tipo_objeto, in_destino_objeto, weT, shift, tira_objetos, andar_atual, addr,
        output tipo_objeto, destino_objeto, tem_vaga
    );
`endif
endinterface

// File: rtl/ram_conteudo_elevador_compacta_objetos.sv
// rtl/ram_conteudo_elevador_compacta_objetos.sv - order-preserving removal of masked slots, survivors packed from slot 0
module compacta_objetos
    import elevador_pkg::*;
(
    input  entry_t           slots_i  [DEPTH],
    input  logic [DEPTH-1:0] valid_i,
    input  logic [DEPTH-1:0] remove_i,
    output entry_t           slots_o  [DEPTH],
    output logic [DEPTH-1:0] valid_o,
    output logic [CNT_W-1:0] count_o
);
    logic [CNT_W-1:0] k;

    always_comb begin
        slots_o = '{default: ENTRY_VAZIA};
        valid_o = '0;
        k       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_i[i] && !remove_i[i]) begin
                slots_o[k[SLOT_W-1:0]] = slots_i[i];
                valid_o[k[SLOT_W-1:0]] = 1'b1;
                k = k + 1'b1;
            end
        end
        count_o = k;
    end
endmodule

// File: rtl/ram_conteudo_elevador.sv
// rtl/ram_conteudo_elevador.sv - ordered cargo queue of the elevator car; RAM_CONTEUDO_CONT_EN exposes quantidade/vazio
module ram_conteudo_elevador
    import elevador_pkg::*;
(
    input  logic                   clk,
    input  logic                   clear,
    ram_conteudo_elevador_if.slave bus
);
    entry_t           ram_q [DEPTH];
    entry_t           ram_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [DEPTH-1:0] remove;
    entry_t           comp_slots [DEPTH];
    logic [DEPTH-1:0] comp_valid;
    logic [CNT_W-1:0] comp_count;
    logic             tem_vaga;
    entry_t           leitura;

    assign tem_vaga = (count_q < CNT_W'(DEPTH));

    // Unload and shift share one compactor; only the removal mask differs
    always_comb begin
        remove = '0;
        if (bus.tira_objetos) begin
            for (int i = 0; i < DEPTH; i++)
                remove[i] = valid_q[i] && (ram_q[i].destino == bus.andar_atual);
        end else if (bus.shift) begin
            remove[0] = valid_q[0];
        end
    end

    compacta_objetos u_compacta (
        .slots_i  (ram_q),
        .valid_i  (valid_q),
        .remove_i (remove),
        .slots_o  (comp_slots),
        .valid_o  (comp_valid),
        .count_o  (comp_count)
    );

    always_comb begin
        ram_d   = ram_q;
        valid_d = valid_q;
        count_d = count_q;
        if (bus.tira_objetos || bus.shift) begin
            ram_d   = comp_slots;
            valid_d = comp_valid;
            count_d = comp_count;
        end else if (bus.weT && tem_vaga) begin
            ram_d[count_q[SLOT_W-1:0]]   = '{tipo: bus.in_tipo_objeto, destino: bus.in_destino_objeto};
            valid_d[count_q[SLOT_W-1:0]] = 1'b1;
            count_d                      = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            ram_q   <= '{default: ENTRY_VAZIA};
            valid_q <= '0;
            count_q <= '0;
        end else begin
            ram_q   <= ram_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        leitura = ENTRY_VAZIA;
        if ((bus.addr < ADDR_W'(DEPTH)) && valid_q[bus.addr[SLOT_W-1:0]])
            leitura = ram_q[bus.addr[SLOT_W-1:0]];
    end

    assign bus.tipo_objeto    = leitura.tipo;
    assign bus.destino_objeto = leitura.destino;
    assign bus.tem_vaga       = tem_vaga;
`ifdef RAM_CONTEUDO_CONT_EN
    assign bus.quantidade     = count_q;
    assign bus.vazio          = (count_q == '0);
`endif
endmodule

// File: tb/tb_ram_conteudo_elevador.sv
// tb/tb_ram_conteudo_elevador.sv - directed and randomized checks of the car content memory against a queue model
module tb_ram_conteudo_elevador;
    import elevador_pkg::*;

    logic clk = 1'b0;
    logic clear;
    int   checks = 0;
    int   errors = 0;
    logic [3:0] model[$];

    ram_conteudo_elevador_if bus ();

    ram_conteudo_elevador dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic read_slot(input int a, output logic [3:0] w);
        bus.addr = 4'(a);
        #1;
        w = {bus.tipo_objeto, bus.destino_objeto};
    endtask

    task automatic check_all(input string tag);
        logic [3:0] w;
        logic [3:0] e;
        for (int a = 0; a < 16; a++) begin
            e = (a < model.size()) ? model[a] : 4'b0000;
            read_slot(a, w);
            check($sformatf("%s slot%0d", tag, a), 32'(w), 32'(e));
        end
        check({tag, " tem_vaga"}, 32'(bus.tem_vaga), 32'(model.size() < 8));
`ifdef RAM_CONTEUDO_CONT_EN
        check({tag, " quantidade"}, 32'(bus.quantidade), 32'(model.size()));
        check({tag, " vazio"}, 32'(bus.vazio), 32'(model.size() == 0));
`endif
    endtask

    task automatic model_apply(input bit t, input bit s, input bit w,
                               input logic [1:0] tipo, input logic [1:0] dest, input logic [1:0] andar);
        logic [3:0] keep[$];
        if (t) begin
            foreach (model[i]) if (model[i][1:0] != andar) keep.push_back(model[i]);
            model = keep;
        end else if (s) begin
            if (model.size() > 0) void'(model.pop_front());
        end else if (w) begin
            if (model.size() < 8) model.push_back({tipo, dest});
        end
    endtask

    task automatic op(input string tag, input bit t, input bit s, input bit w,
                      input logic [1:0] tipo, input logic [1:0] dest, input logic [1:0] andar);
        bus.tira_objetos      = t;
        bus.shift             = s;
        bus.weT               = w;
        bus.in_tipo_objeto    = tipo;
        bus.in_destino_objeto = dest;
        bus.andar_atual       = andar;
        @(posedge clk);
        #2;
        bus.tira_objetos = 1'b0;
        bus.shift        = 1'b0;
        bus.weT          = 1'b0;
        model_apply(t, s, w, tipo, dest, andar);
        check_all(tag);
    endtask

    task automatic pulse_clear(input string tag);
        @(posedge clk);
        #2;
        clear = 1'b1;
        #5;
        model.delete();
        check_all(tag);
        clear = 1'b0;
    endtask

    logic [3:0] w;
    logic [3:0] fill_exp [8];

    initial begin
        clear = 1'b0;
        bus.tira_objetos = 1'b0;
        bus.shift = 1'b0;
        bus.weT = 1'b0;
        bus.in_tipo_objeto = '0;
        bus.in_destino_objeto = '0;
        bus.andar_atual = '0;
        bus.addr = '0;
        fill_exp = '{4'b0001, 4'b0110, 4'b1011, 4'b1100, 4'b0001, 4'b0110, 4'b1011, 4'b1100};

        pulse_clear("reset");

        for (int i = 0; i < 8; i++) op("fill", 0, 0, 1, 2'(i), 2'(i + 1), 2'd0);
        for (int i = 0; i < 8; i++) begin
            read_slot(i, w);
            check($sformatf("fill literal slot%0d", i), 32'(w), 32'(fill_exp[i]));
        end
        check("full tem_vaga", 32'(bus.tem_vaga), 32'd0);
        op("ninth write", 0, 0, 1, 2'd3, 2'd3, 2'd0);

        op("unload floor0", 1, 0, 0, 2'd0, 2'd0, ANDAR_0);
        read_slot(1, w);
        check("floor0 addr1", 32'(w), 32'b0110);
        op("unload floor1", 1, 0, 0, 2'd0, 2'd0, ANDAR_1);
        read_slot(2, w);
        check("floor1 addr2", 32'(w), 32'b0110);
        op("unload floor2", 1, 0, 0, 2'd0, 2'd0, ANDAR_2);
        op("unload floor3", 1, 0, 0, 2'd0, 2'd0, ANDAR_3);
        check("empty tem_vaga", 32'(bus.tem_vaga), 32'd1);

        op("load A", 0, 0, 1, 2'd1, 2'd2, 2'd0);
        op("load B", 0, 0, 1, 2'd2, 2'd3, 2'd0);
        op("load C", 0, 0, 1, 2'd3, 2'd0, 2'd0);
        op("shift3", 0, 1, 0, 2'd0, 2'd0, 2'd0);
        read_slot(0, w);
        check("shift head is B", 32'(w), 32'b1011);
        op("shift2", 0, 1, 0, 2'd0, 2'd0, 2'd0);
        op("shift1", 0, 1, 0, 2'd0, 2'd0, 2'd0);
        op("shift empty", 0, 1, 0, 2'd0, 2'd0, 2'd0);

        op("prio load0", 0, 0, 1, 2'd1, 2'd0, 2'd0);
        op("prio load1", 0, 0, 1, 2'd2, 2'd1, 2'd0);
        op("prio load2", 0, 0, 1, 2'd3, 2'd2, 2'd0);
        op("prio all three", 1, 1, 1, 2'd3, 2'd3, 2'd1);
        op("prio shift over write", 0, 1, 1, 2'd3, 2'd3, 2'd0);

        @(posedge clk);
        #2;
        bus.weT = 1'b1;
        bus.in_tipo_objeto = 2'd2;
        bus.in_destino_objeto = 2'd2;
        #3;
        clear = 1'b1;
        model.delete();
        #1;
        check_all("clear mid fill");
        bus.weT = 1'b0;
        clear = 1'b0;

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                pulse_clear("rand clear");
            end else begin
                op("rand", $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
                   $urandom_range(0, 1) == 1, 2'($urandom), 2'($urandom), 2'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
